param_instr_queue: RTL and testbench

//  In-order instruction queue between decode and dispatch (RS/ROB).

---
 rtl/param_instr_queue_pkg.sv | 42 ++++
 rtl/param_instr_queue_storage.sv | 40 ++++
 rtl/param_instr_queue.sv | 150 +++++++++++++++
 tb/tb_param_instr_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/param_instr_queue_pkg.sv
// -----------------------------------------------------------------------------
// iq_pkg
//   Shared definitions for the in-order instruction queue.
//   - Field widths of one queued instruction (opcode, register indices, imm).
//   - NOP_OP: the all-ones opcode shown on the output when the queue is empty.
//   - iq_entry_t: one queued instruction, packed so it can live in a RAM array.
//   - IQ_ENTRY_IDLE: the value the dispatch side sees when nothing is valid.
// -----------------------------------------------------------------------------
package iq_pkg;

  // Field widths. The queue RTL takes all entry-field widths from here so the
  // storage array and the top-level ports can never disagree.
  localparam int OP_W  = 5;
  localparam int REG_W = 5;
  localparam int IMM_W = 32;

  // All-ones opcode doubles as the NOP/bubble encoding.
  localparam logic [OP_W-1:0] NOP_OP = '1;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic             has_imm;
  } iq_entry_t;

  localparam int ENTRY_W = $bits(iq_entry_t);

  // Output value presented while the queue is empty: a bubble with all other
  // fields zeroed.
  localparam iq_entry_t IQ_ENTRY_IDLE = '{
    op:      NOP_OP,
    rs1:     '0,
    rs2:     '0,
    rd:      '0,
    imm:     '0,
    has_imm: 1'b0
  };

endpackage : iq_pkg

// File: rtl/param_instr_queue_storage.sv
// -----------------------------------------------------------------------------
// iq_storage
//   DEPTH-entry instruction array with one synchronous write port and one
//   asynchronous (combinational) read port. There is no reset on the array:
//   whether an entry holds a live instruction is decided by the occupancy
//   count in the parent, so stale contents are never observed.
// Ports
//   clk      in   1                 clock
//   i_we     in   1                 write enable
//   i_waddr  in   $clog2(DEPTH)     write index (tail)
//   i_wdata  in   iq_entry_t        entry to store
//   i_raddr  in   $clog2(DEPTH)     read index (head)
//   o_rdata  out  iq_entry_t        entry at i_raddr, same cycle
// -----------------------------------------------------------------------------
module iq_storage
  import iq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  iq_entry_t                i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output iq_entry_t                o_rdata
);

  iq_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Combinational read: the head entry is visible in the same cycle the head
  // pointer points at it, so a write at edge N is readable from cycle N+1.
  assign o_rdata = r_mem[i_raddr];

endmodule : iq_storage

// File: rtl/param_instr_queue.sv
// -----------------------------------------------------------------------------
// param_instr_queue
//   In-order instruction queue sitting between decode and dispatch (RS/ROB).
//   Decode pushes with a valid/ready handshake; the head entry is presented to
//   dispatch and retires whenever neither the reservation station nor the
//   reorder buffer is full. Flush clears the queue synchronously and wins over
//   everything else; pause freezes the queue without clearing it.
// Parameters
//   DEPTH        entries, power of two, >= 4
//   FULL_MARGIN  iq_full when count >= DEPTH-FULL_MARGIN
//   AFULL_LVL    almost_full when count >= AFULL_LVL
//   (entry field widths come from iq_pkg)
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   pause, flush        global stall; synchronous clear
//   in_valid/in_ready   enqueue handshake
//   in_op/rs1/rs2/rd/imm/has_imm   instruction being enqueued
//   rs_full, rob_full   dispatch back-pressure
//   out_valid, out_*    head entry (bubble/zeros when empty)
//   issued              registered pulse: a dequeue happened last cycle
//   count               occupancy
//   iq_full, almost_full  watermarks derived from the current count
// -----------------------------------------------------------------------------
module param_instr_queue
  import iq_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 1,
  parameter int AFULL_LVL   = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pause,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [REG_W-1:0]           in_rs1,
  input  logic [REG_W-1:0]           in_rs2,
  input  logic [REG_W-1:0]           in_rd,
  input  logic [IMM_W-1:0]           in_imm,
  input  logic                       in_has_imm,
  input  logic                       rs_full,
  input  logic                       rob_full,
  output logic                       out_valid,
  output logic [OP_W-1:0]            out_op,
  output logic [REG_W-1:0]           out_rs1,
  output logic [REG_W-1:0]           out_rs2,
  output logic [REG_W-1:0]           out_rd,
  output logic [IMM_W-1:0]           out_imm,
  output logic                       out_has_imm,
  output logic                       issued,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       iq_full,
  output logic                       almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0] FULL_LVL_C  = CNT_W'(DEPTH - FULL_MARGIN);
  localparam logic [CNT_W-1:0] AFULL_LVL_C = CNT_W'(AFULL_LVL);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_issued;

  logic             w_enq;
  logic             w_deq;
  logic             w_full;
  logic             w_nonempty;
  iq_entry_t        w_wr_entry;
  iq_entry_t        w_rd_entry;
  iq_entry_t        w_out_entry;

  // Watermarks come straight from the registered count, so they always
  // describe the current occupancy rather than a one-cycle-old value.
  assign w_full      = (r_count >= FULL_LVL_C);
  assign almost_full = (r_count >= AFULL_LVL_C);
  assign iq_full     = w_full;
  assign count       = r_count;

  // Empty/full is decided by count; head==tail is ambiguous on its own.
  assign w_nonempty  = (r_count != '0);

  assign in_ready    = ~w_full & ~pause & ~flush;
  assign w_enq       = in_valid & in_ready;
  assign w_deq       = w_nonempty & ~rs_full & ~rob_full & ~pause & ~flush;

  assign w_wr_entry = '{
    op:      in_op,
    rs1:     in_rs1,
    rs2:     in_rs2,
    rd:      in_rd,
    imm:     in_imm,
    has_imm: in_has_imm
  };

  iq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_enq),
    .i_waddr (r_tail),
    .i_wdata (w_wr_entry),
    .i_raddr (r_head),
    .o_rdata (w_rd_entry)
  );

  // The array is never reset, so gate the head read with validity to keep the
  // outputs defined (bubble + zeros) whenever the queue is empty.
  assign w_out_entry = w_nonempty ? w_rd_entry : IQ_ENTRY_IDLE;

  assign out_valid   = w_nonempty;
  assign out_op      = w_out_entry.op;
  assign out_rs1     = w_out_entry.rs1;
  assign out_rs2     = w_out_entry.rs2;
  assign out_rd      = w_out_entry.rd;
  assign out_imm     = w_out_entry.imm;
  assign out_has_imm = w_out_entry.has_imm;
  assign issued      = r_issued;

  // Pointers wrap DEPTH-1 -> 0 by natural overflow since DEPTH is a power of
  // two. Pause already forces w_enq/w_deq low, but the explicit hold keeps
  // issued frozen as well.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_issued <= 1'b0;
    end else if (flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_issued <= 1'b0;
    end else if (!pause) begin
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_deq) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count  <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      r_issued <= w_deq;
    end
  end

endmodule : param_instr_queue

// File: tb/tb_param_instr_queue.sv
module tb_param_instr_queue;
  import iq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pause = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0, in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [31:0] in_imm = '0;
  logic        in_has_imm = 1'b0;
  logic        rs_full = 1'b0, rob_full = 1'b0;
  logic        out_valid;
  logic [4:0]  out_op, out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic        out_has_imm, issued;
  logic [4:0]  count;
  logic        iq_full, almost_full;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_instr_queue #(.DEPTH(16), .FULL_MARGIN(1), .AFULL_LVL(12)) dut (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_has_imm(in_has_imm),
    .rs_full(rs_full), .rob_full(rob_full),
    .out_valid(out_valid), .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_has_imm(out_has_imm),
    .issued(issued), .count(count), .iq_full(iq_full), .almost_full(almost_full)
  );

  // Side fields are derived from the opcode so each entry is recognisable.
  function automatic logic [4:0] rs1_of(input logic [4:0] op); return op; endfunction
  function automatic logic [4:0] rs2_of(input logic [4:0] op); return ~op; endfunction
  function automatic logic [4:0] rd_of(input logic [4:0] op); return op ^ 5'h0A; endfunction
  function automatic logic [31:0] imm_of(input logic [4:0] op);
    return {op, 3'b101, 19'h0, op};
  endfunction

  typedef struct {
    logic       pause, flush, in_valid, rs_full, rob_full;
    logic [4:0] op;
    logic       e_valid;
    logic [4:0] e_op;
    logic [4:0] e_count;
    logic       e_ready, e_full, e_afull, e_issued;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic p, input logic f, input logic v, input logic rs,
                       input logic rob, input logic [4:0] op);
    pause = p; flush = f; in_valid = v; rs_full = rs; rob_full = rob;
    in_op = op; in_rs1 = rs1_of(op); in_rs2 = rs2_of(op); in_rd = rd_of(op);
    in_imm = imm_of(op); in_has_imm = op[0];
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [4:0] eop,
                           input logic [4:0] ecnt, input logic erdy, input logic efull,
                           input logic eafull, input logic eiss);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".out_op"}, 32'(out_op), ev ? 32'(eop) : 32'h1F);
    chk({tag, ".count"}, 32'(count), 32'(ecnt));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(erdy));
    chk({tag, ".iq_full"}, 32'(iq_full), 32'(efull));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(eafull));
    chk({tag, ".issued"}, 32'(issued), 32'(eiss));
    chk({tag, ".rs1"}, 32'(out_rs1), ev ? 32'(rs1_of(eop)) : 32'h0);
    chk({tag, ".rs2"}, 32'(out_rs2), ev ? 32'(rs2_of(eop)) : 32'h0);
    chk({tag, ".rd"}, 32'(out_rd), ev ? 32'(rd_of(eop)) : 32'h0);
    chk({tag, ".imm"}, out_imm, ev ? imm_of(eop) : 32'h0);
    chk({tag, ".has_imm"}, 32'(out_has_imm), ev ? 32'(eop[0]) : 32'h0);
    $display("[%0t] %s: v=%0b op=%0h cnt=%0d rdy=%0b full=%0b af=%0b iss=%0b",
             $time, tag, out_valid, out_op, count, in_ready, iq_full, almost_full, issued);
  endtask

  task automatic next_edge();
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic p, input logic f, input logic v, input logic rs,
                              input logic rob, input logic [4:0] op, input logic ev,
                              input logic [4:0] eop, input int ecnt, input logic erdy,
                              input logic efull, input logic eafull, input logic eiss);
    vec_t r;
    r.pause = p; r.flush = f; r.in_valid = v; r.rs_full = rs; r.rob_full = rob; r.op = op;
    r.e_valid = ev; r.e_op = eop; r.e_count = 5'(ecnt); r.e_ready = erdy;
    r.e_full = efull; r.e_afull = eafull; r.e_issued = eiss;
    return r;
  endfunction

  initial begin
    // Idle after reset.
    vecs.push_back(mk(0,0,0,0,0, 5'd0, 0, 5'h1F, 0, 1, 0, 0, 0));
    // Fill with ops 1..16 while the RS is full; op 16 must be refused.
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(0,0,1,1,0, 5'(k+1), k > 0, 5'd1, k, k < 15, k >= 15, k >= 12, 0));
    // Drain: ops leave in order, issued trails each dequeue by one cycle.
    for (int j = 0; j < 17; j++)
      vecs.push_back(mk(0,0,0,0,0, 5'd0, j < 15, 5'(j+1), (j < 15) ? 15-j : 0,
                        j >= 1, j == 0, (j < 15) && (15-j >= 12), (j >= 1) && (j <= 15)));
  end

  initial begin
    logic [4:0] op_i;
    logic [4:0] op_prev;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] op_i;
    logic [4:0] op_prev;
    drive(0,0,0,0,0,5'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    next_edge();

    // Table-driven: reset/idle, fill, drain.
    foreach (vecs[i]) begin
      drive(vecs[i].pause, vecs[i].flush, vecs[i].in_valid, vecs[i].rs_full,
            vecs[i].rob_full, vecs[i].op);
      @(negedge clk);
      chk_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_op, vecs[i].e_count,
                vecs[i].e_ready, vecs[i].e_full, vecs[i].e_afull, vecs[i].e_issued);
      next_edge();
    end

    // rob_full alone blocks dispatch.
    drive(0,0,1,0,1,5'd0);
    @(negedge clk); chk_state("rob_a", 0, 5'h1F, 0, 1, 0, 0, 0);
    next_edge();
    drive(0,0,0,0,1,5'd0);
    @(negedge clk); chk_state("rob_b", 1, 5'd0, 1, 1, 0, 0, 0);
    next_edge();

    // Steady enq+deq for 40 cycles; pointers wrap past 15 -> 0.
    op_prev = 5'd0;
    for (int i = 1; i <= 40; i++) begin
      op_i = 5'(i % 31);
      drive(0,0,1,0,0,op_i);
      @(negedge clk);
      chk_state($sformatf("steady%0d", i), 1, op_prev, 1, 1, 0, 0, i >= 2);
      next_edge();
      op_prev = op_i;
    end
    drive(0,0,0,0,0,5'd0);
    @(negedge clk); chk_state("steady_drain", 1, 5'd9, 1, 1, 0, 0, 1);
    next_edge();
    @(negedge clk); chk_state("steady_empty", 0, 5'h1F, 0, 1, 0, 0, 1);
    next_edge();

    // Flush with 6 entries and a concurrent enqueue.
    for (int i = 0; i < 6; i++) begin
      drive(0,0,1,1,0,5'(10+i));
      next_edge();
    end
    drive(0,1,1,0,0,5'd30);
    @(negedge clk); chk_state("flush_pre", 1, 5'd10, 6, 0, 0, 0, 0);
    next_edge();
    drive(0,0,0,1,0,5'd0);
    @(negedge clk); chk_state("flush_post", 0, 5'h1F, 0, 1, 0, 0, 0);
    next_edge();
    drive(0,0,1,1,0,5'd7);
    next_edge();
    drive(0,0,0,1,0,5'd0);
    @(negedge clk); chk_state("flush_reenq", 1, 5'd7, 1, 1, 0, 0, 0);
    next_edge();
    drive(0,1,0,1,0,5'd0);
    next_edge();

    // Pause with 4 entries and issued high; then async reset mid-pause.
    for (int i = 0; i < 5; i++) begin
      drive(0,0,1,1,0,5'(20+i));
      next_edge();
    end
    drive(0,0,0,0,0,5'd0);
    next_edge();
    for (int i = 0; i < 3; i++) begin
      drive(1,0,1,0,0,5'd3);
      @(negedge clk);
      chk_state($sformatf("pause%0d", i), 1, 5'd21, 4, 0, 0, 0, 1);
      next_edge();
    end
    #2 rst = 1'b0;
    #1 chk_state("async_rst", 0, 5'h1F, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0,0,1,1,0,5'd9);
    next_edge();
    drive(0,0,0,1,0,5'd0);
    @(negedge clk); chk_state("post_rst", 1, 5'd9, 1, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_param_instr_queue
